// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Seven-segment glyph constants and hex-to-segment decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Active-low cathode pattern ordered {g,f,e,d,c,b,a}
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_A     = 7'h08;
    localparam seg7_t SEG_B     = 7'h03;
    localparam seg7_t SEG_C     = 7'h46;
    localparam seg7_t SEG_D     = 7'h21;
    localparam seg7_t SEG_E     = 7'h06;
    localparam seg7_t SEG_F     = 7'h0E;

    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        seg7_t w_res;
        w_res = SEG_BLANK;
        case (nibble)
            4'h0: w_res = SEG_0;
            4'h1: w_res = SEG_1;
            4'h2: w_res = SEG_2;
            4'h3: w_res = SEG_3;
            4'h4: w_res = SEG_4;
            4'h5: w_res = SEG_5;
            4'h6: w_res = SEG_6;
            4'h7: w_res = SEG_7;
            4'h8: w_res = SEG_8;
            4'h9: w_res = SEG_9;
            4'hA: w_res = SEG_A;
            4'hB: w_res = SEG_B;
            4'hC: w_res = SEG_C;
            4'hD: w_res = SEG_D;
            4'hE: w_res = SEG_E;
            4'hF: w_res = SEG_F;
            default: w_res = SEG_BLANK;
        endcase
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational nibble to active-low seven-segment decode with blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output seg7_t      o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : hex_to_seg7(i_nibble);

endmodule

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Time-multiplexed 4-digit active-low seven-segment driver with
//                per-frame input latching, decimal points and leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned DIGIT_HZ   = 4_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_mask,
    input  logic        lz_blank,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned     c_DIV      = CLOCK_FREQ / DIGIT_HZ;
    localparam int unsigned     c_CNT_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(c_DIV - 1);

    logic [c_CNT_W-1:0] r_div_cnt;
    logic [1:0]         r_digit_idx;
    logic [15:0]        r_sh_value;
    logic [3:0]         r_sh_dp;
    logic               r_sh_lz;
    logic [3:0]         r_an;
    seg7_t              r_seg;
    logic               r_dp;
    logic               r_frame_tick;

    logic               w_tick;
    logic               w_frame_end;
    logic [1:0]         w_p;
    logic [3:0]         w_upper_zero;
    logic [3:0]         w_nibble;
    logic               w_blank;
    seg7_t              w_seg;

    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_tick && (r_digit_idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit_idx <= 2'd0;
        end else if (w_tick) begin
            r_digit_idx <= r_digit_idx + 2'd1;
        end
    end

    // Shadow registers reload only at the end of digit 3, so every frame is self-consistent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_value   <= 16'h0000;
            r_sh_dp      <= 4'h0;
            r_sh_lz      <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_frame_end) begin
                r_sh_value <= value_in;
                r_sh_dp    <= dp_mask;
                r_sh_lz    <= lz_blank;
            end
        end
    end

    always_comb begin
        w_p = 2'd0;
        if (r_sh_dp[1]) w_p = 2'd1;
        if (r_sh_dp[2]) w_p = 2'd2;
        if (r_sh_dp[3]) w_p = 2'd3;
    end

    assign w_upper_zero[3] = (r_sh_value[15:12] == 4'h0);
    assign w_upper_zero[2] = w_upper_zero[3] && (r_sh_value[11:8] == 4'h0);
    assign w_upper_zero[1] = w_upper_zero[2] && (r_sh_value[7:4]  == 4'h0);
    assign w_upper_zero[0] = w_upper_zero[1] && (r_sh_value[3:0]  == 4'h0);

    always_comb begin
        w_nibble = r_sh_value[3:0];
        case (r_digit_idx)
            2'd0: w_nibble = r_sh_value[3:0];
            2'd1: w_nibble = r_sh_value[7:4];
            2'd2: w_nibble = r_sh_value[11:8];
            2'd3: w_nibble = r_sh_value[15:12];
            default: w_nibble = r_sh_value[3:0];
        endcase
    end

    // Digits at or below the highest lit decimal point are significant and never blanked
    assign w_blank = r_sh_lz && (r_digit_idx > w_p) && w_upper_zero[r_digit_idx];

    seg7_decoder u_decoder (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 4'hF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_tick) begin
            r_an  <= enable ? ~(4'b0001 << r_digit_idx) : 4'hF;
            r_seg <= w_seg;
            r_dp  <= ~r_sh_dp[r_digit_idx];
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
//  Module      : tb_seven_seg_scanner
//  Description : Directed self-checking bench for seven_seg_scanner (DIV = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    seven_seg_scanner #(
        .CLOCK_FREQ (16),
        .DIGIT_HZ   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample point is 1 time unit after the n-th following rising edge
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After this, rising edge k (k=1,2,...) is cycle k; ticks land on k = 4,8,12,...
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp_an;
        #1 reset = 1'b1;
        #1;
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an an=%h expected=%h", an, 4'hF); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg seg=%h expected=%h", seg, 7'h7F); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp dp=%b expected=1", dp); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_ft frame_tick=%b expected=0", frame_tick); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycles(1);
            exp_an = 4'hF;
            if (k >= 4) exp_an = ~(4'b0001 << (((k - 4) / 4) % 4));
            checks++; if (an !== exp_an) begin failures++; $display("FAIL walk_an cyc=%0d an=%h expected=%h", k, an, exp_an); end
            if (k == 4) begin
                checks++; if (seg !== 7'h40) begin failures++; $display("FAIL walk_seg0 seg=%h expected=%h", seg, 7'h40); end
                checks++; if (dp !== 1'b1) begin failures++; $display("FAIL walk_dp0 dp=%b expected=1", dp); end
            end
        end
    endtask

    task automatic test_hex;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_seg[0] = 7'h19; exp_seg[1] = 7'h30; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
        exp_an[0]  = 4'hE;  exp_an[1]  = 4'hD;  exp_an[2]  = 4'hB;  exp_an[3]  = 4'h7;
        value_in = 16'h1234; dp_mask = 4'h0; lz_blank = 1'b0; enable = 1'b1;
        do_reset;
        cycles(15);
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL hex_ft15 frame_tick=%b expected=0", frame_tick); end
        cycles(1);
        checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL hex_ft16 frame_tick=%b expected=1", frame_tick); end
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL hex_oldshadow seg=%h expected=%h", seg, 7'h40); end
        cycles(1);
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL hex_ft17 frame_tick=%b expected=0", frame_tick); end
        cycles(3);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) cycles(4);
            checks++; if (an !== exp_an[d]) begin failures++; $display("FAIL hex_an d=%0d an=%h expected=%h", d, an, exp_an[d]); end
            checks++; if (seg !== exp_seg[d]) begin failures++; $display("FAIL hex_seg d=%0d seg=%h expected=%h", d, seg, exp_seg[d]); end
            checks++; if (dp !== 1'b1) begin failures++; $display("FAIL hex_dp d=%0d dp=%b expected=1", d, dp); end
        end
    endtask

    task automatic test_lz_blank;
        logic [6:0] exp_seg [8];
        logic       exp_dp  [8];
        exp_seg[0] = 7'h12; exp_seg[1] = 7'h24; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h7F;
        exp_seg[4] = 7'h12; exp_seg[5] = 7'h24; exp_seg[6] = 7'h40; exp_seg[7] = 7'h40;
        for (int i = 0; i < 8; i++) exp_dp[i] = 1'b1;
        exp_dp[7] = 1'b0;
        value_in = 16'h0025; dp_mask = 4'h0; lz_blank = 1'b1; enable = 1'b1;
        do_reset;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            cycles(4);
            checks++; if (seg !== exp_seg[i]) begin failures++; $display("FAIL lz_seg step=%0d seg=%h expected=%h", i, seg, exp_seg[i]); end
            checks++; if (dp !== exp_dp[i]) begin failures++; $display("FAIL lz_dp step=%0d dp=%b expected=%b", i, dp, exp_dp[i]); end
            if (i == 0) dp_mask = 4'b1000;
        end
    endtask

    task automatic test_all_zero;
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h40; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h7F;
        value_in = 16'h0000; dp_mask = 4'h0; lz_blank = 1'b1; enable = 1'b1;
        do_reset;
        cycles(16);
        for (int d = 0; d < 4; d++) begin
            cycles(4);
            checks++; if (seg !== exp_seg[d]) begin failures++; $display("FAIL zero_seg d=%0d seg=%h expected=%h", d, seg, exp_seg[d]); end
        end
    endtask

    task automatic test_back_to_back;
        int         ft_cnt;
        logic [6:0] exp_seg;
        ft_cnt = 0;
        value_in = 16'h1111; dp_mask = 4'h0; lz_blank = 1'b0; enable = 1'b1;
        do_reset;
        cycles(16);
        for (int k = 17; k <= 48; k++) begin
            cycles(1);
            if (frame_tick === 1'b1) ft_cnt++;
            if (k % 4 == 0) begin
                exp_seg = (k < 36) ? 7'h79 : 7'h24;
                checks++; if (seg !== exp_seg) begin failures++; $display("FAIL b2b_seg cyc=%0d seg=%h expected=%h", k, seg, exp_seg); end
            end
            if (k == 20) value_in = 16'h2222;
        end
        checks++; if (ft_cnt != 2) begin failures++; $display("FAIL b2b_ftcount count=%0d expected=2", ft_cnt); end
    endtask

    task automatic test_enable;
        value_in = 16'h1234; dp_mask = 4'h0; lz_blank = 1'b0; enable = 1'b1;
        do_reset;
        cycles(4);
        checks++; if (an !== 4'hE) begin failures++; $display("FAIL en_an4 an=%h expected=%h", an, 4'hE); end
        cycles(1);
        enable = 1'b0;
        checks++; if (an !== 4'hE) begin failures++; $display("FAIL en_hold5 an=%h expected=%h", an, 4'hE); end
        cycles(3);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL en_off8 an=%h expected=%h", an, 4'hF); end
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL en_seg8 seg=%h expected=%h", seg, 7'h40); end
        cycles(4);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL en_off12 an=%h expected=%h", an, 4'hF); end
        cycles(1);
        enable = 1'b1;
        cycles(2);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL en_hold15 an=%h expected=%h", an, 4'hF); end
        cycles(1);
        checks++; if (an !== 4'h7) begin failures++; $display("FAIL en_resume16 an=%h expected=%h", an, 4'h7); end
        cycles(4);
        checks++; if (an !== 4'hE) begin failures++; $display("FAIL en_an20 an=%h expected=%h", an, 4'hE); end
        checks++; if (seg !== 7'h19) begin failures++; $display("FAIL en_seg20 seg=%h expected=%h", seg, 7'h19); end
    endtask

    initial begin
        reset    = 1'b0;
        value_in = 16'h0000;
        dp_mask  = 4'h0;
        lz_blank = 1'b0;
        enable   = 1'b1;
        test_reset;
        test_hex;
        test_lz_blank;
        test_all_zero;
        test_back_to_back;
        test_enable;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
